// File: rtl/booth_seq_pkg.sv
// Shared types and sizing helpers for the sequential radix-4 Booth multiplier.
package booth_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One group per two multiplier bits plus the zero-extension group on top.
    function automatic int grp_count(input int width);
        return width / 2 + 1;
    endfunction

    function automatic int acc_width(input int width);
        return 2 * width + 2;
    endfunction

    localparam int DEFAULT_WIDTH = 16;
    localparam int ACC_W         = acc_width(DEFAULT_WIDTH);

endpackage

// File: rtl/booth_pp_row.sv
// One radix-4 Booth partial-product row: group decode, magnitude select and negate.
module booth_pp_row #(
    parameter int WIDTH = 16
) (
    input  logic               [2:0]       g,
    input  logic               [WIDTH-1:0] yr,
    output logic signed        [WIDTH+1:0] pp
);

    logic             w_single;
    logic             w_double;
    logic             w_neg;
    logic [WIDTH+1:0] w_mag;

    // Group 111 selects zero magnitude, so its negation is still zero.
    always_comb begin
        w_single = g[0] ^ g[1];
        w_double = (g == 3'b011) || (g == 3'b100);
        w_neg    = g[2];
        w_mag    = '0;
        if (w_single) begin
            w_mag = {2'b00, yr};
        end else if (w_double) begin
            w_mag = {1'b0, yr, 1'b0};
        end
        pp = w_neg ? -w_mag : w_mag;
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Iterative radix-4 Booth multiplier: a single partial-product row is reused for
// every group, one group per clock, accumulated into a 2*WIDTH+2 bit register.
module booth_seq_ctrl
    import booth_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int GROUP_CNT = grp_count(WIDTH);
    localparam int CNT_W     = $clog2(GROUP_CNT);
    localparam int ACC_BITS  = acc_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUP_CNT - 1);

    state_t                  r_state;
    state_t                  w_nextState;
    logic [WIDTH+2:0]        r_xr;
    logic [WIDTH-1:0]        r_yr;
    logic [ACC_BITS-1:0]     r_acc;
    logic [CNT_W-1:0]        r_grpCnt;
    logic [2*WIDTH-1:0]      r_product;

    logic signed [WIDTH+1:0] w_pp;
    logic [ACC_BITS-1:0]     w_ppExt;
    logic [ACC_BITS-1:0]     w_accNext;
    logic                    w_lastGrp;

    booth_pp_row #(
        .WIDTH (WIDTH)
    ) u_ppRow (
        .g  (r_xr[2:0]),
        .yr (r_yr),
        .pp (w_pp)
    );

    // Sign-extended row weighted by 4^grp_cnt; the sum wraps modulo 2^ACC_BITS.
    assign w_ppExt   = {{(ACC_BITS - WIDTH - 2){w_pp[WIDTH+1]}}, w_pp};
    assign w_accNext = r_acc + (w_ppExt << {r_grpCnt, 1'b0});
    assign w_lastGrp = (r_grpCnt == LAST_GRP);

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign product   = r_product;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_nextState = RUN;
            RUN:     if (w_lastGrp) w_nextState = DONE;
            DONE:    if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The multiplier is stored pre-shifted with an implicit zero below bit 0,
    // so the low three bits are always the current Booth group.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xr      <= '0;
            r_yr      <= '0;
            r_acc     <= '0;
            r_grpCnt  <= '0;
            r_product <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_xr     <= {2'b00, x, 1'b0};
                        r_yr     <= y;
                        r_acc    <= '0;
                        r_grpCnt <= '0;
                    end
                end
                RUN: begin
                    r_acc    <= w_accNext;
                    r_xr     <= r_xr >> 2;
                    r_grpCnt <= r_grpCnt + CNT_W'(1);
                    if (w_lastGrp) begin
                        r_product <= w_accNext[2*WIDTH-1:0];
                        assert (w_accNext[ACC_BITS-1:2*WIDTH] == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
